trigger_filter: RTL and testbench

Glitch filter for the selected trigger line in the io channel. It takes the selected line input and rejects high pulses no longer than a programmable rise width, and low pulses no longer than a programmable fall width. It drives the filtered line consumed by trigger_active and by the trigger debug counters, and it flags every rejected pulse for debug.

---
 rtl/trigger_filter_pkg.sv | 19 +
 rtl/trigger_filter_cnt.sv | 30 +++
 rtl/trigger_filter.sv | 144 ++++++++++++++
 tb/tb_trigger_filter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_filter_pkg.sv
// Shared io_channel definitions for the trigger filter and trigger_active:
// filter-width default and the binary encoding of the filter FSM states.
package trigger_filter_pkg;

  localparam int FILTER_WD_DEF = 16;

  localparam logic [1:0] ST_STABLE_LOW  = 2'd0;
  localparam logic [1:0] ST_RISE_CHECK  = 2'd1;
  localparam logic [1:0] ST_STABLE_HIGH = 2'd2;
  localparam logic [1:0] ST_FALL_CHECK  = 2'd3;

  typedef enum logic [1:0] {
    STABLE_LOW  = ST_STABLE_LOW,
    RISE_CHECK  = ST_RISE_CHECK,
    STABLE_HIGH = ST_STABLE_HIGH,
    FALL_CHECK  = ST_FALL_CHECK
  } filt_state_t;

endpackage

// File: rtl/trigger_filter_cnt.sv
// Pulse-length counter shared by the rise and fall checks. The caller picks
// which shadow width it is compared against; only one check runs at a time.
module trigger_filter_cnt #(
  parameter int FILTER_WD = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 inc,
  input  logic [FILTER_WD-1:0] width,
  output logic                 eq
);

  logic [FILTER_WD-1:0] cnt;

  // Clear has priority; the FSM leaves the check on equality, so the
  // counter never reaches the wrap point and needs no saturation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + FILTER_WD'(1);
    end
  end

  assign eq = (cnt == width);

endmodule

// File: rtl/trigger_filter.sv
// Glitch filter for the selected trigger line: high pulses of at most
// W_rise samples and low pulses of at most W_fall samples are rejected and
// flagged with a one-cycle glitch pulse.
module trigger_filter
  import trigger_filter_pkg::*;
#(
  parameter int FILTER_WD = FILTER_WD_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_linein_sel,
  input  logic [FILTER_WD-1:0] iv_filter_rise,
  input  logic [FILTER_WD-1:0] iv_filter_fall,
  output logic                 o_linein_filter,
  output logic                 o_glitch_rise,
  output logic                 o_glitch_fall,
  output logic                 o_filter_busy
);

  filt_state_t          state_q;
  filt_state_t          state_d;
  logic [FILTER_WD-1:0] sh_rise;
  logic [FILTER_WD-1:0] sh_fall;
  logic [FILTER_WD-1:0] w_sel;
  logic                 cnt_clr;
  logic                 cnt_inc;
  logic                 cnt_eq;
  logic                 filt_q;
  logic                 glitch_rise_q;
  logic                 glitch_rise_d;
  logic                 glitch_fall_q;
  logic                 glitch_fall_d;
  logic                 stable;

  assign stable = (state_q == STABLE_LOW) || (state_q == STABLE_HIGH);

  // Low-side states compare against the rise width, high-side against fall.
  assign w_sel = ((state_q == STABLE_LOW) || (state_q == RISE_CHECK)) ? sh_rise : sh_fall;

  trigger_filter_cnt #(
    .FILTER_WD (FILTER_WD)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .width   (w_sel),
    .eq      (cnt_eq)
  );

  // Shadow widths track the ports while stable and freeze during a check,
  // so a width change mid-check only affects the next check.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_rise <= '0;
      sh_fall <= '0;
    end else if (stable) begin
      sh_rise <= iv_filter_rise;
      sh_fall <= iv_filter_fall;
    end
  end

  // State register plus registered line and glitch outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= STABLE_LOW;
      filt_q        <= 1'b0;
      glitch_rise_q <= 1'b0;
      glitch_fall_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      filt_q        <= (state_d == STABLE_HIGH) || (state_d == FALL_CHECK);
      glitch_rise_q <= glitch_rise_d;
      glitch_fall_q <= glitch_fall_d;
    end
  end

  // Next state, counter control and glitch detection.
  always_comb begin
    state_d       = state_q;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    glitch_rise_d = 1'b0;
    glitch_fall_d = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        if (i_linein_sel && (w_sel == '0)) begin
          state_d = STABLE_HIGH;
          cnt_clr = 1'b1;
        end else if (i_linein_sel) begin
          state_d = RISE_CHECK;
          cnt_inc = 1'b1;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      RISE_CHECK: begin
        if (!i_linein_sel) begin
          state_d       = STABLE_LOW;
          glitch_rise_d = 1'b1;
          cnt_clr       = 1'b1;
        end else if (cnt_eq) begin
          state_d = STABLE_HIGH;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      STABLE_HIGH: begin
        if (!i_linein_sel && (w_sel == '0)) begin
          state_d = STABLE_LOW;
          cnt_clr = 1'b1;
        end else if (!i_linein_sel) begin
          state_d = FALL_CHECK;
          cnt_inc = 1'b1;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      FALL_CHECK: begin
        if (i_linein_sel) begin
          state_d       = STABLE_HIGH;
          glitch_fall_d = 1'b1;
          cnt_clr       = 1'b1;
        end else if (cnt_eq) begin
          state_d = STABLE_LOW;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_clr = 1'b1;
      end
    endcase
  end

  assign o_linein_filter = filt_q;
  assign o_glitch_rise   = glitch_rise_q;
  assign o_glitch_fall   = glitch_fall_q;
  assign o_filter_busy   = (state_q == RISE_CHECK) || (state_q == FALL_CHECK);

endmodule

// File: tb/tb_trigger_filter.sv
// Bench for trigger_filter: directed scenarios plus randomized pulse trains,
// every cycle compared against a run-length reference model.
module tb_trigger_filter;

  localparam int FILTER_WD = 16;

  logic                 clk;
  logic                 reset_n;
  logic                 i_linein_sel;
  logic [FILTER_WD-1:0] iv_filter_rise;
  logic [FILTER_WD-1:0] iv_filter_fall;
  logic                 o_linein_filter;
  logic                 o_glitch_rise;
  logic                 o_glitch_fall;
  logic                 o_filter_busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: filtered level, length of the current opposite-level
  // run, width latched for that run, and the shadow widths.
  logic m_lvl;
  int   m_run;
  int   m_wlat;
  int   m_shr;
  int   m_shf;
  logic m_gr;
  logic m_gf;

  trigger_filter #(
    .FILTER_WD (FILTER_WD)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_linein_sel    (i_linein_sel),
    .iv_filter_rise  (iv_filter_rise),
    .iv_filter_fall  (iv_filter_fall),
    .o_linein_filter (o_linein_filter),
    .o_glitch_rise   (o_glitch_rise),
    .o_glitch_fall   (o_glitch_fall),
    .o_filter_busy   (o_filter_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl  = 1'b0;
    m_run  = 0;
    m_wlat = 0;
    m_shr  = 0;
    m_shf  = 0;
    m_gr   = 1'b0;
    m_gf   = 1'b0;
  endtask

  // One sampling edge: x is the sampled line, wr/wf the port widths.
  task automatic model_step(input logic x, input int wr, input int wf);
    int w_old;
    m_gr = 1'b0;
    m_gf = 1'b0;
    if (m_run == 0) begin
      w_old = m_lvl ? m_shf : m_shr;
      m_shr = wr;
      m_shf = wf;
      if (x != m_lvl) begin
        if (w_old == 0) begin
          m_lvl = x;
        end else begin
          m_run  = 1;
          m_wlat = m_lvl ? m_shf : m_shr;
        end
      end
    end else begin
      if (x == m_lvl) begin
        if (m_lvl) m_gf = 1'b1;
        else       m_gr = 1'b1;
        m_run = 0;
      end else if (m_run == m_wlat) begin
        m_lvl = x;
        m_run = 0;
      end else begin
        m_run++;
      end
    end
  endtask

  task automatic check_model();
    check("filter", 32'(o_linein_filter), 32'(m_lvl));
    check("glitch_rise", 32'(o_glitch_rise), 32'(m_gr));
    check("glitch_fall", 32'(o_glitch_fall), 32'(m_gf));
    check("busy", 32'(o_filter_busy), 32'(m_run != 0));
    check("glitch_excl", 32'(o_glitch_rise & o_glitch_fall), 32'd0);
  endtask

  // Drive one sample (inputs change on the falling edge), then check.
  task automatic tick(input logic x);
    i_linein_sel = x;
    @(posedge clk);
    model_step(x, int'(iv_filter_rise), int'(iv_filter_fall));
    @(negedge clk);
    check_model();
  endtask

  initial begin
    reset_n        = 1'b0;
    i_linein_sel   = 1'b0;
    iv_filter_rise = '0;
    iv_filter_fall = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_filter", 32'(o_linein_filter), 32'd0);
    check("rst_glitch", 32'({o_glitch_rise, o_glitch_fall}), 32'd0);
    check("rst_busy", 32'(o_filter_busy), 32'd0);
    reset_n = 1'b1;

    // Zero widths: one-cycle registered pass-through.
    tick(1'b0);
    tick(1'b1);
    check("w0_rise", 32'(o_linein_filter), 32'd1);
    tick(1'b0);
    check("w0_fall", 32'(o_linein_filter), 32'd0);

    // W_rise=5: a 5-sample pulse is rejected, a 6-sample pulse passes.
    iv_filter_rise = 16'd5;
    tick(1'b0);
    repeat (5) tick(1'b1);
    check("r5_hold", 32'(o_linein_filter), 32'd0);
    tick(1'b0);
    check("r5_glitch", 32'(o_glitch_rise), 32'd1);
    tick(1'b0);
    repeat (5) tick(1'b1);
    check("r6_wait", 32'(o_linein_filter), 32'd0);
    tick(1'b1);
    check("r6_pass", 32'(o_linein_filter), 32'd1);
    check("r6_noglitch", 32'(o_glitch_rise), 32'd0);

    // W_fall=3: a 3-sample dip is rejected, a 4-sample dip passes.
    iv_filter_fall = 16'd3;
    tick(1'b1);
    repeat (3) tick(1'b0);
    check("f3_hold", 32'(o_linein_filter), 32'd1);
    tick(1'b1);
    check("f3_glitch", 32'(o_glitch_fall), 32'd1);
    tick(1'b1);
    repeat (3) tick(1'b0);
    check("f4_wait", 32'(o_linein_filter), 32'd1);
    tick(1'b0);
    check("f4_pass", 32'(o_linein_filter), 32'd0);

    // Width change mid-check applies only to the next check.
    iv_filter_rise = 16'd10;
    tick(1'b0);
    repeat (4) tick(1'b1);
    iv_filter_rise = 16'd2;
    repeat (6) tick(1'b1);
    check("shadow_wait", 32'(o_linein_filter), 32'd0);
    tick(1'b1);
    check("shadow_old_w", 32'(o_linein_filter), 32'd1);
    repeat (4) tick(1'b0);
    check("shadow_fall", 32'(o_linein_filter), 32'd0);
    repeat (2) tick(1'b1);
    check("shadow_new_wait", 32'(o_linein_filter), 32'd0);
    tick(1'b1);
    check("shadow_new_w", 32'(o_linein_filter), 32'd1);

    // Toggling every cycle: output constant, fall glitch every 2 cycles.
    tick(1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0);
      tick(1'b1);
      check("toggle_glitch", 32'(o_glitch_fall), 32'd1);
      check("toggle_level", 32'(o_linein_filter), 32'd1);
    end

    // Maximum width: rise after exactly 65536 high samples.
    iv_filter_fall = 16'd0;
    tick(1'b1);
    tick(1'b0);
    iv_filter_rise = 16'hFFFF;
    tick(1'b0);
    repeat (65535) tick(1'b1);
    check("wmax_wait", 32'(o_linein_filter), 32'd0);
    check("wmax_busy", 32'(o_filter_busy), 32'd1);
    tick(1'b1);
    check("wmax_pass", 32'(o_linein_filter), 32'd1);

    // Reset asserted at cnt=7 of a rise check.
    tick(1'b0);
    iv_filter_rise = 16'd10;
    tick(1'b0);
    repeat (7) tick(1'b1);
    check("prerst_busy", 32'(o_filter_busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_filter", 32'(o_linein_filter), 32'd0);
    check("midrst_busy", 32'(o_filter_busy), 32'd0);
    check("midrst_glitch", 32'({o_glitch_rise, o_glitch_fall}), 32'd0);
    model_reset();
    @(negedge clk);
    check("midrst_glitch2", 32'({o_glitch_rise, o_glitch_fall}), 32'd0);
    iv_filter_rise = 16'd2;
    i_linein_sel   = 1'b0;
    reset_n        = 1'b1;
    tick(1'b0);
    repeat (2) tick(1'b1);
    check("postrst_wait", 32'(o_linein_filter), 32'd0);
    tick(1'b1);
    check("postrst_pass", 32'(o_linein_filter), 32'd1);

    // Randomized pulse trains with occasional width changes.
    for (int n = 0; n < 600; n++) begin
      logic lvl;
      int   len;
      if ($urandom_range(0, 7) == 0) iv_filter_rise = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) iv_filter_fall = 16'($urandom_range(0, 6));
      lvl = n[0];
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 31) == 0) iv_filter_rise = 16'($urandom_range(0, 6));
        tick(lvl);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
